// File: rtl/z80_bus_arbiter_if.sv
// Shared memory-bus bundle between the three Z80-system masters, the slave side
// and the bus arbiter. The arbiter connects through the slave modport.
interface z80_bus_arbiter_if;
  logic        i_m0_cs;
  logic        i_m0_we;
  logic [15:0] i_m0_addr;
  logic [7:0]  i_m0_dat;
  logic        o_m0_grant;
  logic        o_m0_ack;

  logic        i_m1_cs;
  logic        i_m1_we;
  logic [15:0] i_m1_addr;
  logic [7:0]  i_m1_dat;
  logic        o_m1_grant;
  logic        o_m1_ack;

  logic        i_m2_cs;
  logic        i_m2_we;
  logic [15:0] i_m2_addr;
  logic [7:0]  i_m2_dat;
  logic        o_m2_grant;
  logic        o_m2_ack;

  logic [7:0]  o_rd_dat;
  logic [15:0] o_addr;
  logic [7:0]  o_dat;
  logic        o_we;
  logic        o_cs;
  logic        i_ack;
  logic [7:0]  i_dat;
  logic        o_timeout;
  logic [1:0]  o_owner;

  modport slave (
    input  i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
    input  i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
    input  i_m2_cs, i_m2_we, i_m2_addr, i_m2_dat,
    input  i_ack, i_dat,
    output o_m0_grant, o_m0_ack, o_m1_grant, o_m1_ack, o_m2_grant, o_m2_ack,
    output o_rd_dat, o_addr, o_dat, o_we, o_cs, o_timeout, o_owner
  );

  modport master (
    output i_m0_cs, i_m0_we, i_m0_addr, i_m0_dat,
    output i_m1_cs, i_m1_we, i_m1_addr, i_m1_dat,
    output i_m2_cs, i_m2_we, i_m2_addr, i_m2_dat,
    output i_ack, i_dat,
    input  o_m0_grant, o_m0_ack, o_m1_grant, o_m1_ack, o_m2_grant, o_m2_ack,
    input  o_rd_dat, o_addr, o_dat, o_we, o_cs, o_timeout, o_owner
  );
endinterface

// File: rtl/z80_bus_arbiter.sv
// Fixed-priority, starvation-protected three-master arbiter for the Z80 memory bus,
// with a per-transaction slave timeout and a DONE hold until the owner releases cs.
module z80_bus_arbiter #(
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              i_clk,
  input logic              i_reset,
  z80_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;
  localparam logic [1:0] NO_OWNER = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [2:0]  grant_q, grant_d;
  logic [2:0]  ack_q, ack_d;
  logic        timeout_q, timeout_d;
  logic [7:0]  rd_q, rd_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic [3:0]  starve_q [3];
  logic [3:0]  starve_d [3];

  logic [2:0]  cs_v, we_v;
  logic [15:0] addr_v [3];
  logic [7:0]  dat_v [3];
  logic [2:0]  starved;
  logic [1:0]  winner;
  logic        owner_cs;

  assign cs_v      = {bus.i_m2_cs, bus.i_m1_cs, bus.i_m0_cs};
  assign we_v      = {bus.i_m2_we, bus.i_m1_we, bus.i_m0_we};
  assign addr_v[0] = bus.i_m0_addr;
  assign addr_v[1] = bus.i_m1_addr;
  assign addr_v[2] = bus.i_m2_addr;
  assign dat_v[0]  = bus.i_m0_dat;
  assign dat_v[1]  = bus.i_m1_dat;
  assign dat_v[2]  = bus.i_m2_dat;

  function automatic logic [1:0] lowest(input logic [2:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else           return 2'd2;
  endfunction

  always_comb begin
    starved = '0;
    for (int unsigned i = 0; i < 3; i++)
      starved[i] = cs_v[i] && (starve_q[i] >= 4'(STARVE_LIMIT));
    winner = (|starved) ? lowest(starved) : lowest(cs_v);
  end

  always_comb begin
    owner_cs = 1'b0;
    for (int unsigned i = 0; i < 3; i++)
      if (owner_q == 2'(i)) owner_cs = cs_v[i];
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    grant_d   = grant_q;
    ack_d     = '0;
    timeout_d = 1'b0;
    rd_d      = rd_q;
    tcnt_d    = tcnt_q;
    for (int unsigned i = 0; i < 3; i++) starve_d[i] = starve_q[i];

    case (state_q)
      IDLE: begin
        if (|cs_v) begin
          for (int unsigned i = 0; i < 3; i++) begin
            grant_d[i] = (winner == 2'(i));
            if (winner == 2'(i))
              starve_d[i] = '0;
            else if (cs_v[i] && starve_q[i] != 4'hF)
              starve_d[i] = starve_q[i] + 4'd1;
          end
          owner_d = winner;
          tcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // An owner that drops cs aborts; that takes precedence over any ack.
        if (!owner_cs) begin
          owner_d = NO_OWNER;
          grant_d = '0;
          state_d = IDLE;
        end else if (bus.i_ack) begin
          rd_d    = bus.i_dat;
          ack_d   = grant_q;
          state_d = DONE;
        end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
          rd_d      = 8'hFF;
          ack_d     = grant_q;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      DONE: begin
        if (!owner_cs) begin
          owner_d = NO_OWNER;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        owner_d = NO_OWNER;
        grant_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= IDLE;
      owner_q   <= NO_OWNER;
      grant_q   <= '0;
      ack_q     <= '0;
      timeout_q <= 1'b0;
      rd_q      <= '0;
      tcnt_q    <= '0;
      for (int unsigned i = 0; i < 3; i++) starve_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      timeout_q <= timeout_d;
      rd_q      <= rd_d;
      tcnt_q    <= tcnt_d;
      for (int unsigned i = 0; i < 3; i++) starve_q[i] <= starve_d[i];
    end
  end

  always_comb begin
    bus.o_cs   = 1'b0;
    bus.o_we   = 1'b0;
    bus.o_addr = '0;
    bus.o_dat  = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (state_q == GRANT && owner_q == 2'(i)) begin
        bus.o_cs   = cs_v[i];
        bus.o_we   = we_v[i];
        bus.o_addr = addr_v[i];
        bus.o_dat  = dat_v[i];
      end
    end
  end

  assign bus.o_m0_grant = grant_q[0];
  assign bus.o_m1_grant = grant_q[1];
  assign bus.o_m2_grant = grant_q[2];
  assign bus.o_m0_ack   = ack_q[0];
  assign bus.o_m1_ack   = ack_q[1];
  assign bus.o_m2_ack   = ack_q[2];
  assign bus.o_rd_dat   = rd_q;
  assign bus.o_timeout  = timeout_q;
  assign bus.o_owner    = owner_q;
endmodule
